// File: rtl/sa_feed_pkg.sv
// Shared types and helpers for the systolic-array skew feeder.
// Optional stall counter in sa_skew_feeder is enabled by defining SA_FEED_STALL_CNT_EN.
package sa_feed_pkg;

    localparam int LANES_DEF = 3;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 4;
    localparam int ROWS_DEF  = 6;

    // Widest lane and packed row the slice helper can handle.
    localparam int MAX_DW    = 32;
    localparam int MAX_BUS_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } feed_state_e;

    // Extract lane k (dw bits wide) from a packed row, zero-extended to MAX_DW.
    function automatic logic [MAX_DW-1:0] lane_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          k,
        input int unsigned          dw
    );
        logic [MAX_BUS_W-1:0] shifted;
        shifted    = bus >> (k * dw);
        lane_slice = shifted[MAX_DW-1:0] & ((MAX_DW'(1) << dw) - MAX_DW'(1));
    endfunction

endpackage

// File: rtl/sa_feed_fifo.sv
// Synchronous FIFO with occupancy count; no fall-through, a pushed word is
// readable the cycle after it is written. DEPTH must be a power of two.
module sa_feed_fifo
    import sa_feed_pkg::*;
#(
    parameter int W     = LANES_DEF * DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          full;
    logic          push_en;
    logic          pop_en;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        empty    = (count_q == '0);
        push_en  = push && !full;
        pop_en   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/sa_skew_feeder.sv
// Buffers activation rows and issues one diagonally skewed frame per start.
// Define SA_FEED_STALL_CNT_EN to add the stall_cnt output (empty-FIFO STREAM cycles).
module sa_skew_feeder
    import sa_feed_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int ROWS  = ROWS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    output logic                  out_en,
    output logic [LANES*DW-1:0]   out_data,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            row_count
`ifdef SA_FEED_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int FCW = (LANES > 2) ? $clog2(LANES - 1) : 1;

    feed_state_e         state_q, state_d;
    logic [3:0]          row_cnt_q, row_cnt_d;
    logic [FCW-1:0]      flush_cnt_q, flush_cnt_d;
    logic                out_en_q, out_en_d;
    logic                adv;
    logic                inject_zero;
    logic                clear_skew;
    logic                fifo_pop;
    logic [LANES*DW-1:0] fifo_rdata;
    logic [AW:0]         fifo_count;
    logic                fifo_empty;

    sa_feed_fifo #(
        .W     (LANES * DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign in_ready = (fifo_count != (AW+1)'(DEPTH));

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        flush_cnt_d = flush_cnt_q;
        adv         = 1'b0;
        inject_zero = 1'b0;
        clear_skew  = 1'b0;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clear_skew = 1'b1;
                    row_cnt_d  = '0;
                    state_d    = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    adv       = 1'b1;
                    row_cnt_d = row_cnt_q + 4'd1;
                    if (row_cnt_q == 4'(ROWS - 1)) begin
                        flush_cnt_d = '0;
                        state_d     = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // Zeros pushed into every chain head let the trailing lanes drain.
                adv         = 1'b1;
                inject_zero = 1'b1;
                if (flush_cnt_q == FCW'(LANES - 2)) begin
                    state_d = ST_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FCW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        out_en_d = adv;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_cnt_q   <= '0;
            flush_cnt_q <= '0;
            out_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            out_en_q    <= out_en_d;
        end
    end

    // Lane k owns a (k+1)-stage chain whose last stage drives its out_data slice,
    // so lane k trails lane 0 by exactly k advances.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DW-1:0] head;
        logic [DW-1:0] chain_q [k+1];
        logic [DW-1:0] chain_d [k+1];

        always_comb begin
            head = inject_zero ? '0 : DW'(lane_slice(MAX_BUS_W'(fifo_rdata), k, DW));
            for (int j = 0; j <= k; j++) begin
                chain_d[j] = chain_q[j];
            end
            if (clear_skew) begin
                for (int j = 0; j <= k; j++) begin
                    chain_d[j] = '0;
                end
            end else if (adv) begin
                chain_d[0] = head;
                for (int j = 1; j <= k; j++) begin
                    chain_d[j] = chain_q[j-1];
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= k; j++) begin
                    chain_q[j] <= '0;
                end
            end else begin
                for (int j = 0; j <= k; j++) begin
                    chain_q[j] <= chain_d[j];
                end
            end
        end

        assign out_data[k*DW +: DW] = chain_q[k];
    end

`ifdef SA_FEED_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_IDLE && start) begin
            stall_cnt_d = '0;
        end else if (state_q == ST_STREAM && fifo_empty && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign out_en    = out_en_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign row_count = row_cnt_q;

endmodule
